// File: rtl/wram_bank_controller.sv
// rtl/wram_bank_controller.sv - banked working RAM with an SVBK bank select and a post-reset zero scrub
// Optional feature: define WRAM_ECHO_EN to alias both windows 2W bytes above the fixed window.
module wram_bank_controller #(
  parameter int          NUM_BANKS      = 8,
  parameter int          BANK_ADDR_BITS = 12,
  parameter logic [15:0] BASE_ADDR      = 16'hC000,
  parameter logic [15:0] SVBK_ADDR      = 16'hFF70
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_IOREG_ADDR,
  inout  wire  [7:0]  IO_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  input  logic [15:0] I_WRAM_ADDR,
  inout  wire  [7:0]  IO_WRAM_DATA,
  input  logic        I_WRAM_WE_L,
  input  logic        I_WRAM_RE_L,
  input  logic        I_IN_DMG_MODE,
  output logic        O_BUSY
);

  localparam int BSEL  = $clog2(NUM_BANKS);
  localparam int IDX_W = BSEL + BANK_ADDR_BITS;
  localparam int DEPTH = NUM_BANKS << BANK_ADDR_BITS;
  localparam logic [31:0]      WIN      = 32'd1 << BANK_ADDR_BITS;
  localparam logic [31:0]      BASE32   = {16'd0, BASE_ADDR};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_SCRUB = 1'b0, ST_READY = 1'b1} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] scrub_cnt, next_cnt;
  logic [BSEL-1:0]  svbk;
  logic [BSEL-1:0]  eff_bank;
  logic [BSEL-1:0]  bank;
  logic [31:0]      addr32, addr_alias;
  logic             in_fixed, in_switch, in_range;
  logic [IDX_W-1:0] ram_idx;
  logic             wr_en, rd_go, svbk_we, svbk_re;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [7:0]       mem_wdata;
  logic [7:0]       rd_data;
  logic             rd_flag;
  logic [7:0]       mem [DEPTH];

  assign eff_bank = (I_IN_DMG_MODE || svbk == '0) ? BSEL'(1) : svbk;

  // The echo region is folded onto the primary windows before decode so both share one path.
  always_comb begin
    addr32     = {16'd0, I_WRAM_ADDR};
    addr_alias = addr32;
`ifdef WRAM_ECHO_EN
    if (addr32 >= BASE32 + 32'd2 * WIN && addr32 <= BASE32 + 32'd4 * WIN - 32'h201)
      addr_alias = addr32 - 32'd2 * WIN;
`else
    addr_alias = addr32;
`endif
    in_fixed  = (addr_alias >= BASE32) && (addr_alias < BASE32 + WIN);
    in_switch = (addr_alias >= BASE32 + WIN) && (addr_alias < BASE32 + 32'd2 * WIN);
    in_range  = in_fixed || in_switch;
    bank      = in_switch ? eff_bank : '0;
    ram_idx   = {bank, I_WRAM_ADDR[BANK_ADDR_BITS-1:0]};
  end

  always_comb begin
    next_state = state;
    next_cnt   = scrub_cnt;
    wr_en      = 1'b0;
    rd_go      = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = ram_idx;
    mem_wdata  = IO_WRAM_DATA;
    case (state)
      ST_SCRUB: begin
        mem_we    = 1'b1;
        mem_widx  = scrub_cnt;
        mem_wdata = 8'h00;
        next_cnt  = scrub_cnt + 1'b1;
        if (scrub_cnt == LAST_IDX) next_state = ST_READY;
      end
      default: begin
        wr_en  = !I_WRAM_WE_L && in_range;
        rd_go  = !I_WRAM_RE_L && I_WRAM_WE_L && in_range;
        mem_we = wr_en;
      end
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state     <= ST_SCRUB;
      scrub_cnt <= '0;
    end else begin
      state     <= next_state;
      scrub_cnt <= next_cnt;
    end
  end

  assign svbk_we = !I_IOREG_WE_L && I_IOREG_ADDR == SVBK_ADDR && !I_IN_DMG_MODE;
  assign svbk_re = !I_IOREG_RE_L && I_IOREG_ADDR == SVBK_ADDR;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      svbk    <= '0;
      rd_flag <= 1'b0;
    end else begin
      if (svbk_we) svbk <= I_IOREG_DATA_low(IO_IOREG_DATA);
      rd_flag <= rd_go;
    end
  end

  function automatic logic [BSEL-1:0] I_IOREG_DATA_low(input logic [7:0] d);
    return d[BSEL-1:0];
  endfunction

  // Storage has no reset; the scrub is what clears it.
  always_ff @(posedge I_CLK) begin
    if (mem_we && !I_RESET) mem[mem_widx] <= mem_wdata;
    if (rd_go) rd_data <= mem[ram_idx];
  end

  assign IO_WRAM_DATA  = rd_flag ? rd_data : 8'hzz;
  assign IO_IOREG_DATA = svbk_re ? {{(8 - BSEL){1'b1}}, svbk} : 8'hzz;
  assign O_BUSY        = (state == ST_SCRUB);

endmodule

// File: tb/tb_wram_bank_controller.sv
// tb/tb_wram_bank_controller.sv - directed self-checking bench for wram_bank_controller
module tb_wram_bank_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_addr;
  logic        io_we_l, io_re_l, io_drv;
  logic [7:0]  io_dout;
  logic [15:0] wram_addr;
  logic        wram_we_l, wram_re_l, wram_drv;
  logic [7:0]  wram_dout;
  logic        dmg;
  logic        busy;
  tri1  [7:0]  io_bus;
  tri1  [7:0]  wram_bus;

  int compared = 0;
  int mismatched = 0;

  assign io_bus   = io_drv   ? io_dout   : 8'hzz;
  assign wram_bus = wram_drv ? wram_dout : 8'hzz;

  always #5 clk = ~clk;

  wram_bank_controller dut (
    .I_CLK         (clk),
    .I_RESET       (reset),
    .I_IOREG_ADDR  (io_addr),
    .IO_IOREG_DATA (io_bus),
    .I_IOREG_WE_L  (io_we_l),
    .I_IOREG_RE_L  (io_re_l),
    .I_WRAM_ADDR   (wram_addr),
    .IO_WRAM_DATA  (wram_bus),
    .I_WRAM_WE_L   (wram_we_l),
    .I_WRAM_RE_L   (wram_re_l),
    .I_IN_DMG_MODE (dmg),
    .O_BUSY        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wram_write(input logic [15:0] a, input logic [7:0] d);
    wram_addr = a; wram_dout = d; wram_drv = 1'b1; wram_we_l = 1'b0;
    tick();
    wram_we_l = 1'b1; wram_drv = 1'b0;
  endtask

  task automatic wram_read(input logic [15:0] a, output logic [7:0] d);
    wram_addr = a; wram_re_l = 1'b0;
    tick();
    d = wram_bus;
    wram_re_l = 1'b1;
    tick();
  endtask

  task automatic io_write(input logic [7:0] d);
    io_addr = 16'hFF70; io_dout = d; io_drv = 1'b1; io_we_l = 1'b0;
    tick();
    io_we_l = 1'b1; io_drv = 1'b0;
  endtask

  task automatic io_read(output logic [7:0] d);
    io_addr = 16'hFF70; io_re_l = 1'b0;
    #1;
    d = io_bus;
    io_re_l = 1'b1;
    #1;
  endtask

  task automatic count_busy(input int start, output int n);
    n = start;
    while (busy && n < 40000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int n;
    reset = 1'b1;
    repeat (3) tick();
    compared++;
    if (busy !== 1'b1) begin $display("FAIL reset_busy got %b want 1", busy); mismatched++; end
    compared++;
    if (wram_bus !== 8'hFF) begin $display("FAIL reset_wram_bus got %h want ff(undriven)", wram_bus); mismatched++; end
    io_read(d);
    compared++;
    if (d !== 8'hF8) begin $display("FAIL reset_svbk got %h want f8", d); mismatched++; end
    reset = 1'b0;
    count_busy(0, n);
    compared++;
    if (n !== 32768) begin $display("FAIL scrub_length got %0d want 32768", n); mismatched++; end
    wram_read(16'hC123, d);
    compared++;
    if (d !== 8'h00) begin $display("FAIL scrub_read_c123 got %h want 00", d); mismatched++; end
  endtask

  task automatic test_banking();
    logic [7:0] d;
    wram_write(16'hD010, 8'hA5);
    io_write(8'd3);
    wram_write(16'hD010, 8'h5A);
    io_write(8'd1);
    wram_read(16'hD010, d);
    compared++;
    if (d !== 8'hA5) begin $display("FAIL bank1_read got %h want a5", d); mismatched++; end
    io_write(8'd3);
    wram_read(16'hD010, d);
    compared++;
    if (d !== 8'h5A) begin $display("FAIL bank3_read got %h want 5a", d); mismatched++; end
    wram_read(16'hC010, d);
    compared++;
    if (d !== 8'h00) begin $display("FAIL bank0_read got %h want 00", d); mismatched++; end
    wram_write(16'hC000, 8'hEE);
    wram_read(16'hC000, d);
    compared++;
    if (d !== 8'hEE) begin $display("FAIL c000_read got %h want ee", d); mismatched++; end
  endtask

  task automatic test_svbk_dmg();
    logic [7:0] d;
    io_write(8'd5);
    io_read(d);
    compared++;
    if (d !== 8'hFD) begin $display("FAIL svbk_read got %h want fd", d); mismatched++; end
    dmg = 1'b1;
    io_write(8'd7);
    io_read(d);
    compared++;
    if (d !== 8'hFD) begin $display("FAIL svbk_dmg_write got %h want fd", d); mismatched++; end
    wram_read(16'hD010, d);
    compared++;
    if (d !== 8'hA5) begin $display("FAIL dmg_window1 got %h want a5", d); mismatched++; end
    dmg = 1'b0;
    wram_read(16'hD010, d);
    compared++;
    if (d !== 8'h00) begin $display("FAIL bank5_read got %h want 00", d); mismatched++; end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    wram_addr = 16'hC200; wram_dout = 8'h3C; wram_drv = 1'b1;
    wram_we_l = 1'b0; wram_re_l = 1'b0;
    tick();
    wram_we_l = 1'b1; wram_re_l = 1'b1; wram_drv = 1'b0;
    #1;
    compared++;
    if (wram_bus !== 8'hFF) begin $display("FAIL collision_no_drive got %h want ff(undriven)", wram_bus); mismatched++; end
    tick();
    wram_read(16'hC200, d);
    compared++;
    if (d !== 8'h3C) begin $display("FAIL collision_write got %h want 3c", d); mismatched++; end
    wram_read(16'hB000, d);
    compared++;
    if (d !== 8'hFF) begin $display("FAIL out_of_range got %h want ff(undriven)", d); mismatched++; end
  endtask

  task automatic test_back_to_back();
    io_write(8'd3);
    wram_addr = 16'hC200; wram_re_l = 1'b0;
    tick();
    compared++;
    if (wram_bus !== 8'h3C) begin $display("FAIL b2b_first got %h want 3c", wram_bus); mismatched++; end
    wram_addr = 16'hD010;
    io_addr = 16'hFF70; io_dout = 8'd1; io_drv = 1'b1; io_we_l = 1'b0;
    tick();
    io_we_l = 1'b1; io_drv = 1'b0;
    compared++;
    if (wram_bus !== 8'h5A) begin $display("FAIL b2b_old_bank got %h want 5a", wram_bus); mismatched++; end
    tick();
    compared++;
    if (wram_bus !== 8'hA5) begin $display("FAIL b2b_new_bank got %h want a5", wram_bus); mismatched++; end
    wram_re_l = 1'b1;
    tick();
    compared++;
    if (wram_bus !== 8'hFF) begin $display("FAIL b2b_release got %h want ff(undriven)", wram_bus); mismatched++; end
  endtask

  task automatic test_echo();
    logic [7:0] d;
    wram_write(16'hE456, 8'h77);
`ifdef WRAM_ECHO_EN
    wram_read(16'hC456, d);
    compared++;
    if (d !== 8'h77) begin $display("FAIL echo_alias got %h want 77", d); mismatched++; end
    wram_read(16'hE456, d);
    compared++;
    if (d !== 8'h77) begin $display("FAIL echo_read got %h want 77", d); mismatched++; end
`else
    wram_read(16'hE456, d);
    compared++;
    if (d !== 8'hFF) begin $display("FAIL echo_off_read got %h want ff(undriven)", d); mismatched++; end
    wram_read(16'hC456, d);
    compared++;
    if (d !== 8'h00) begin $display("FAIL echo_off_c456 got %h want 00", d); mismatched++; end
`endif
  endtask

  task automatic test_midscrub_reset();
    logic [7:0] d;
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (1000) tick();
    compared++;
    if (busy !== 1'b1) begin $display("FAIL midscrub_busy got %b want 1", busy); mismatched++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    wram_write(16'hC000, 8'h99);
    count_busy(6, n);
    compared++;
    if (n !== 32768) begin $display("FAIL rescrub_length got %0d want 32768", n); mismatched++; end
    wram_read(16'hC000, d);
    compared++;
    if (d !== 8'h00) begin $display("FAIL scrub_write_dropped got %h want 00", d); mismatched++; end
  endtask

  initial begin
    reset = 1'b1;
    io_addr = 16'h0000; io_we_l = 1'b1; io_re_l = 1'b1; io_drv = 1'b0; io_dout = 8'h00;
    wram_addr = 16'h0000; wram_we_l = 1'b1; wram_re_l = 1'b1; wram_drv = 1'b0; wram_dout = 8'h00;
    dmg = 1'b0;
    test_reset();
    test_banking();
    test_svbk_dmg();
    test_collision();
    test_back_to_back();
    test_echo();
    test_midscrub_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
